// File: rtl/soft_err_pkg.sv
// Shared types and constants for the soft-error monitor channels.
// Combinational definitions only: no latency, no backpressure.
package soft_err_pkg;
   localparam int COUNT_W = 32;
   localparam logic [COUNT_W-1:0] COUNT_MAX = 32'hFFFF_FFFF;
   localparam int NUM_CH = 3;
   localparam int CH_CS = 0;
   localparam int CH_TTC = 1;
   localparam int CH_DDR3 = 2;

   typedef enum logic {
      OK      = 1'b0,
      TRIPPED = 1'b1
   } ch_state_t;
endpackage

// File: rtl/soft_err_channel.sv
// One event channel: saturating counter plus sticky threshold FSM.
// Count updates 1 cycle after an event; the flag trips 1 cycle after the count reaches threshold.
// No backpressure: every event pulse is accepted unless err_clear is active.
module soft_err_channel
   import soft_err_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               evt,
   input  logic               clear,
   input  logic               wrap,
   input  logic [COUNT_W-1:0] thres,
   output logic [COUNT_W-1:0] count,
   output logic               flag
);
   logic [COUNT_W-1:0] count_q;
   logic [COUNT_W-1:0] count_d;
   ch_state_t          state_q;
   ch_state_t          state_d;

   // Clear beats both window wrap and a same-cycle event.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (wrap) begin
         count_d = evt ? COUNT_W'(1) : '0;
      end else if (evt && (count_q != COUNT_MAX)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         OK:      if ((thres != '0) && (count_q >= thres)) state_d = TRIPPED;
         TRIPPED: state_d = TRIPPED;
         default: state_d = OK;
      endcase
      if (clear) state_d = OK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         state_q <= OK;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   assign count = count_q;
   assign flag  = (state_q == TRIPPED);
endmodule

// File: rtl/soft_error_monitor.sv
// Soft-error counters with sticky threshold flags; SOFT_ERR_WINDOW_EN turns counts into per-window rates.
// Counts lag events by 1 cycle, flags by 2; thresholds are registered once before use.
// No backpressure: event pulses are always accepted.
module soft_error_monitor
   import soft_err_pkg::*;
#(
   parameter logic [31:0] WINDOW_CYCLES = 32'd125_000_000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cs_mismatch,
   input  logic               unknown_ttc,
   input  logic               ddr3_overflow,
   input  logic               err_clear,
   input  logic [COUNT_W-1:0] thres_data_corrupt,
   input  logic [COUNT_W-1:0] thres_unknown_ttc,
   input  logic [COUNT_W-1:0] thres_ddr3_overflow,
   output logic [COUNT_W-1:0] cs_mismatch_count,
   output logic [COUNT_W-1:0] unknown_cmd_count,
   output logic [COUNT_W-1:0] ddr3_overflow_count,
   output logic               error_data_corrupt,
   output logic               error_unknown_ttc,
   output logic               ddr3_overflow_warning,
   output logic [COUNT_W-1:0] thres_data_corrupt_out,
   output logic [COUNT_W-1:0] thres_unknown_ttc_out,
   output logic [COUNT_W-1:0] thres_ddr3_overflow_out
);
   logic [1:0] rst_sync;
   logic       rst_int_n;
   logic       wrap;

   // Assert immediately, release after two clean edges.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_int_n = rst_sync[1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         thres_data_corrupt_out  <= '0;
         thres_unknown_ttc_out   <= '0;
         thres_ddr3_overflow_out <= '0;
      end else begin
         thres_data_corrupt_out  <= thres_data_corrupt;
         thres_unknown_ttc_out   <= thres_unknown_ttc;
         thres_ddr3_overflow_out <= thres_ddr3_overflow;
      end
   end

`ifdef SOFT_ERR_WINDOW_EN
   logic [31:0] win_cnt;

   assign wrap = (win_cnt == (WINDOW_CYCLES - 32'd1));

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)  win_cnt <= '0;
      else if (wrap)   win_cnt <= '0;
      else             win_cnt <= win_cnt + 32'd1;
   end
`else
   logic unused_window;
   assign unused_window = ^WINDOW_CYCLES;
   assign wrap = 1'b0;
`endif

   soft_err_channel u_ch_cs (
      .clk   (clk),
      .rst_n (rst_int_n),
      .evt   (cs_mismatch),
      .clear (err_clear),
      .wrap  (wrap),
      .thres (thres_data_corrupt_out),
      .count (cs_mismatch_count),
      .flag  (error_data_corrupt)
   );

   soft_err_channel u_ch_ttc (
      .clk   (clk),
      .rst_n (rst_int_n),
      .evt   (unknown_ttc),
      .clear (err_clear),
      .wrap  (wrap),
      .thres (thres_unknown_ttc_out),
      .count (unknown_cmd_count),
      .flag  (error_unknown_ttc)
   );

   soft_err_channel u_ch_ddr3 (
      .clk   (clk),
      .rst_n (rst_int_n),
      .evt   (ddr3_overflow),
      .clear (err_clear),
      .wrap  (wrap),
      .thres (thres_ddr3_overflow_out),
      .count (ddr3_overflow_count),
      .flag  (ddr3_overflow_warning)
   );
endmodule

// File: tb/tb_soft_error_monitor.sv
// Self-checking bench for soft_error_monitor: vector table with expectation queue plus corner-case sequences.
module tb_soft_error_monitor;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        cs_mismatch, unknown_ttc, ddr3_overflow, err_clear;
   logic [31:0] thres_data_corrupt, thres_unknown_ttc, thres_ddr3_overflow;
   logic [31:0] cs_mismatch_count, unknown_cmd_count, ddr3_overflow_count;
   logic        error_data_corrupt, error_unknown_ttc, ddr3_overflow_warning;
   logic [31:0] thres_data_corrupt_out, thres_unknown_ttc_out, thres_ddr3_overflow_out;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic        cs;
      logic        ttc;
      logic        ddr;
      logic        clr;
      logic [31:0] c_cs;
      logic [31:0] c_ttc;
      logic [31:0] c_ddr;
      logic [2:0]  flags;   // {ddr3_warning, unknown_ttc, data_corrupt}
   } vec_t;

   vec_t vecs[10];
   vec_t exp_q[$];

   soft_error_monitor #(.WINDOW_CYCLES(32'd16)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .cs_mismatch             (cs_mismatch),
      .unknown_ttc             (unknown_ttc),
      .ddr3_overflow           (ddr3_overflow),
      .err_clear               (err_clear),
      .thres_data_corrupt      (thres_data_corrupt),
      .thres_unknown_ttc       (thres_unknown_ttc),
      .thres_ddr3_overflow     (thres_ddr3_overflow),
      .cs_mismatch_count       (cs_mismatch_count),
      .unknown_cmd_count       (unknown_cmd_count),
      .ddr3_overflow_count     (ddr3_overflow_count),
      .error_data_corrupt      (error_data_corrupt),
      .error_unknown_ttc       (error_unknown_ttc),
      .ddr3_overflow_warning   (ddr3_overflow_warning),
      .thres_data_corrupt_out  (thres_data_corrupt_out),
      .thres_unknown_ttc_out   (thres_unknown_ttc_out),
      .thres_ddr3_overflow_out (thres_ddr3_overflow_out)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   function automatic logic [31:0] flags_now();
      return {29'd0, ddr3_overflow_warning, error_unknown_ttc, error_data_corrupt};
   endfunction

   // Drive one cycle of pulses at the falling edge and return #1 after the next rising edge.
   task automatic tick(input logic cs, input logic ttc, input logic ddr, input logic clr);
      @(negedge clk);
      cs_mismatch   = cs;
      unknown_ttc   = ttc;
      ddr3_overflow = ddr;
      err_clear     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      vec_t e;
      logic found;

      // Thresholds for the table: corrupt=3, ttc disabled, ddr3=2.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, 3'b000};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd1, 32'd0, 3'b000};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 32'd1, 32'd1, 3'b000};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd1, 32'd1, 3'b001};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd3, 32'd1, 32'd2, 3'b001};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd2, 32'd2, 3'b101};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 32'd3, 32'd3, 3'b101};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 3'b000};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, 3'b000};
      vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, 3'b000};

      reset_n             = 1'b0;
      cs_mismatch         = 1'b0;
      unknown_ttc         = 1'b0;
      ddr3_overflow       = 1'b0;
      err_clear           = 1'b0;
      thres_data_corrupt  = 32'd3;
      thres_unknown_ttc   = 32'd0;
      thres_ddr3_overflow = 32'd2;

      #12;
      check("rst_cs_count", cs_mismatch_count, 32'd0);
      check("rst_ttc_count", unknown_cmd_count, 32'd0);
      check("rst_ddr_count", ddr3_overflow_count, 32'd0);
      check("rst_flags", flags_now(), 32'd0);
      check("rst_thres_dc_out", thres_data_corrupt_out, 32'd0);
      check("rst_thres_ddr_out", thres_ddr3_overflow_out, 32'd0);

      @(negedge clk);
      reset_n = 1'b1;
      idle(4);
      check("thres_dc_out", thres_data_corrupt_out, 32'd3);
      check("thres_ttc_out", thres_unknown_ttc_out, 32'd0);
      check("thres_ddr_out", thres_ddr3_overflow_out, 32'd2);

      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(vecs[i]);
         tick(vecs[i].cs, vecs[i].ttc, vecs[i].ddr, vecs[i].clr);
         e = exp_q.pop_front();
         check($sformatf("vec%0d_cs_count", i), cs_mismatch_count, e.c_cs);
         check($sformatf("vec%0d_ttc_count", i), unknown_cmd_count, e.c_ttc);
         check($sformatf("vec%0d_ddr_count", i), ddr3_overflow_count, e.c_ddr);
         check($sformatf("vec%0d_flags", i), flags_now(), {29'd0, e.flags});
      end

      // Threshold zero disables the flag regardless of count.
      thres_data_corrupt = 32'd0;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
      check("thres0_count", cs_mismatch_count, 32'd10);
      check("thres0_flag", 32'(error_data_corrupt), 32'd0);

      // Saturation from a forced near-max count.
      @(negedge clk);
      force dut.u_ch_cs.count_q = 32'hFFFF_FFFE;
      #1;
      release dut.u_ch_cs.count_q;
      check("sat_preload", cs_mismatch_count, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0);
         check($sformatf("sat_pulse%0d", i), cs_mismatch_count, 32'hFFFF_FFFF);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      check("sat_cleared", cs_mismatch_count, 32'd0);

      // Clear colliding with an event while tripped.
      thres_unknown_ttc = 32'd5;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      check("coll_pre_count", unknown_cmd_count, 32'd5);
      check("coll_pre_flag", 32'(error_unknown_ttc), 32'd1);
      tick(1'b0, 1'b1, 1'b0, 1'b1);
      check("coll_count", unknown_cmd_count, 32'd0);
      check("coll_flag", 32'(error_unknown_ttc), 32'd0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      check("coll_next_count", unknown_cmd_count, 32'd1);
      idle(1);
      check("coll_next_flag", 32'(error_unknown_ttc), 32'd0);

      // Stickiness against threshold changes.
      thres_ddr3_overflow = 32'd2;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("sticky_before_trip", 32'(ddr3_overflow_warning), 32'd0);
      idle(1);
      check("sticky_trip", 32'(ddr3_overflow_warning), 32'd1);
      thres_ddr3_overflow = 32'd100;
      idle(3);
      check("sticky_raise", 32'(ddr3_overflow_warning), 32'd1);
      thres_ddr3_overflow = 32'd1;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      check("sticky_lower_flag", 32'(ddr3_overflow_warning), 32'd0);
      check("sticky_lower_count", ddr3_overflow_count, 32'd0);
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      check("sticky_retrip_wait", 32'(ddr3_overflow_warning), 32'd0);
      idle(1);
      check("sticky_retrip", 32'(ddr3_overflow_warning), 32'd1);

      // Asynchronous reset between edges, then events during the release window.
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check("arst_cs_count", cs_mismatch_count, 32'd0);
      check("arst_ddr_count", ddr3_overflow_count, 32'd0);
      check("arst_flags", flags_now(), 32'd0);
      check("arst_thres_ddr_out", thres_ddr3_overflow_out, 32'd0);
      @(negedge clk);
      reset_n       = 1'b1;
      cs_mismatch   = 1'b1;
      ddr3_overflow = 1'b1;
      @(posedge clk);
      @(posedge clk);
      idle(2);
      check("release_cs_ignored", cs_mismatch_count, 32'd0);
      check("release_ddr_ignored", ddr3_overflow_count, 32'd0);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("release_first_event", cs_mismatch_count, 32'd1);

`ifdef SOFT_ERR_WINDOW_EN
      thres_data_corrupt = 32'd3;
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick(1'b0, 1'b0, 1'b0, 1'b0);
         if (cs_mismatch_count == 32'd0) found = 1'b1;
      end
      check("win_find_wrap", 32'(found), 32'd1);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("win_count4", cs_mismatch_count, 32'd4);
      idle(11);
      check("win_pre_wrap_count", cs_mismatch_count, 32'd4);
      check("win_pre_wrap_flag", 32'(error_data_corrupt), 32'd1);
      idle(1);
      check("win_wrap_count", cs_mismatch_count, 32'd0);
      check("win_wrap_flag", 32'(error_data_corrupt), 32'd1);
      idle(15);
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("win_wrap_event", cs_mismatch_count, 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/soft_error_monitor.md
# soft_error_monitor

Counts soft-error events and declares the data-corruption and unknown-TTC hard errors and the DDR3-overflow warning once each count reaches its programmable threshold. The block sits directly upstream of the status register block. It drives the `cs_mismatch_count`, `unknown_cmd_count` and `ddr3_overflow_count` words, plus the `error_data_corrupt`, `error_unknown_ttc` and `ddr3_overflow_warning` flags, and it passes the three thresholds through unchanged for readback. Event pulses come from the checksum checker, the TTC decoder and the DDR3 write controller, all in the same clock domain.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 32'd125_000_000. Length of the counting window in clocks. Used only when `SOFT_ERR_WINDOW_EN` is defined.

Ports:
- `clk`, input, 1. User interface clock.
- `reset_n`, input, 1. Reset is asynchronous and active-low.
- `cs_mismatch`, input, 1. One-cycle pulse: checksum mismatch event.
- `unknown_ttc`, input, 1. One-cycle pulse: unknown TTC broadcast command.
- `ddr3_overflow`, input, 1. One-cycle pulse: DDR3 overflow event.
- `err_clear`, input, 1. One-cycle pulse: clear all counts and all flags.
- `thres_data_corrupt`, input, 32. Corruption threshold; 0 disables the flag.
- `thres_unknown_ttc`, input, 32. Unknown-TTC threshold; 0 disables the flag.
- `thres_ddr3_overflow`, input, 32. DDR3-overflow threshold; 0 disables the flag.
- `cs_mismatch_count`, output, 32. Saturating event count.
- `unknown_cmd_count`, output, 32. Saturating event count.
- `ddr3_overflow_count`, output, 32. Saturating event count.
- `error_data_corrupt`, output, 1. Sticky hard error.
- `error_unknown_ttc`, output, 1. Sticky hard error.
- `ddr3_overflow_warning`, output, 1. Sticky warning.
- `thres_*_out`, output, 32 each. Registered copies of the three thresholds, for readback.

## Operation
- Three identical channels. Each channel has a 32-bit counter and a two-state FSM: OK and TRIPPED.
- Counter rules:
  - An event pulse increments the count by 1.
  - The count saturates at 32'hFFFF_FFFF and never wraps.
- FSM rules:
  - OK -> TRIPPED when the threshold is nonzero and count >= threshold.
  - TRIPPED -> OK only on `err_clear` or on reset.
  - In TRIPPED, the flag output is 1.
- Threshold changes:
  - The comparison is evaluated every cycle against the current threshold.
  - Raising or zeroing the threshold while in TRIPPED does not release the flag.
  - Lowering the threshold to or below the current count trips the flag on the next cycle.
- `err_clear` has priority over a same-cycle event. The count becomes 0 and that event is dropped.
- Channels are fully independent. Simultaneous events on several channels each increment their own channel.
- Reset values, all taken asynchronously on `reset_n` = 0:
  - All counts: 0.
  - All flags: 0.
  - Threshold copies: 0.
  - FSMs: OK.
  - Window counter: 0.

## Timing
- An event sampled at rising edge N appears in the count output after edge N. Latency is 1 cycle.
- The flag compares the registered count. It asserts after edge N+1, 2 cycles after the event that reaches the threshold.
- `err_clear` sampled at edge N:
  - Counts and flags read 0 after edge N.
  - An event at edge N+1 counts normally.
- Threshold inputs are registered with 1 cycle of latency before use in the comparison.
- Reset deassertion is synchronised inside the block with a two-flop release. The first event is accepted 2 cycles after `reset_n` rises.
- Asserting `reset_n` mid-count clears everything immediately, without waiting for a clock.

## Configuration
- Macro: `SOFT_ERR_WINDOW_EN`.
- When defined:
  - A free-running window counter runs from 0 to `WINDOW_CYCLES`-1.
  - On the wrap cycle, all three counts reset to 0, or to 1 if that channel has an event in the same cycle.
  - Flags stay sticky.
  - The thresholds therefore act as rate limits (events per window).
- When undefined:
  - There is no window counter.
  - Counts accumulate until `err_clear` or reset.
  - The `WINDOW_CYCLES` parameter is ignored.

## Structure
- Package `soft_err_pkg` holds:
  - `COUNT_W` = 32.
  - `COUNT_MAX` = 32'hFFFF_FFFF.
  - The channel FSM state typedef (OK, TRIPPED).
  - Channel index constants: CH_CS = 0, CH_TTC = 1, CH_DDR3 = 2.
- Sub-module `soft_err_channel`:
  - Contains the counter, the FSM and the comparator.
  - Is instantiated three times.
- The top level holds the threshold registers, the reset synchroniser and the optional window counter.

## Test plan
- Threshold saturation: set `thres_data_corrupt` = 3 and send 3 `cs_mismatch` pulses. Required: count = 3 and `error_data_corrupt` = 1, arriving 2 cycles after the third pulse. With threshold = 0, 10 pulses must give count = 10 and flag = 0.
- Counter saturation: preload `cs_mismatch_count` to 32'hFFFF_FFFE by force, then send 3 pulses. Required: count = 32'hFFFF_FFFF and no wrap.
- Clear collision: assert `err_clear` and `unknown_ttc` in the same cycle while the count is 5 and the flag is set. Required: count = 0 and flag = 0. A pulse on the next cycle gives count = 1.
- Stickiness: trip `ddr3_overflow_warning` at threshold 2, then write threshold 100. Required: the warning stays at 1. Lowering the threshold to 1 with count 0 after a clear must not trip.
- Reset mid-operation: drop `reset_n` asynchronously between edges. Required: all outputs are 0 before the next edge. Events in the 2 cycles after release are ignored.
- Window (build with `SOFT_ERR_WINDOW_EN`, `WINDOW_CYCLES` = 16): send 4 events, then wait for the wrap. Required: count returns to 0 and any tripped flag remains 1. An event on the wrap cycle leaves count = 1.
